// File: rtl/mc_core.sv
// mc_core: parametrised multicycle core (PC, register file, ALU, zero flag, FETCH/EXEC/MEM/HALT FSM).
// Optional performance counters (cyc_cnt, ret_cnt) are built when MC_CORE_PERF_EN is defined.
module mc_core #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int PCW  = 8,
    parameter int AW   = 8,
    localparam int RAW = $clog2(NREG),
    localparam int IW  = 3 + 2 * RAW
) (
    input  logic           clk,
    input  logic           reset,
    output logic [PCW-1:0] im_addr,
    input  logic [IW-1:0]  im_inst,
    output logic           dm_req,
    output logic           dm_we,
    output logic [AW-1:0]  dm_addr,
    output logic [DW-1:0]  dm_wdata,
    input  logic           dm_ack,
    input  logic [DW-1:0]  dm_rdata,
    output logic           done,
    output logic           z,
`ifdef MC_CORE_PERF_EN
    output logic [31:0]    cyc_cnt,
    output logic [31:0]    ret_cnt,
`endif
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDR = 3'd0;
    localparam logic [2:0] OP_STR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;
    localparam logic [2:0] OP_DEC = 3'd5;
    localparam logic [2:0] OP_BZ  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [PCW-1:0]  pc;
    logic [DW-1:0]   regs [NREG];

    logic [2:0]              op;
    logic [RAW-1:0]          ra;
    logic [RAW-1:0]          rb;
    logic signed [2*RAW-1:0] off;
    logic [DW-1:0]           ra_val;
    logic [DW-1:0]           rb_val;
    logic [DW-1:0]           alu_res;
    logic [PCW-1:0]          pc_inc;
    logic [PCW-1:0]          pc_br;

    assign op     = ir[IW-1:IW-3];
    assign ra     = ir[2*RAW-1:RAW];
    assign rb     = ir[RAW-1:0];
    assign off    = ir[2*RAW-1:0];
    assign ra_val = regs[ra];
    assign rb_val = regs[rb];

    // PC arithmetic wraps modulo 2^PCW; the offset is sign-extended by the signed cast.
    assign pc_inc = pc + PCW'(1);
    assign pc_br  = pc + PCW'(off);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = ra_val + rb_val;
            OP_SUB:  alu_res = ra_val - rb_val;
            OP_CLR:  alu_res = '0;
            OP_DEC:  alu_res = ra_val - DW'(1);
            default: alu_res = '0;
        endcase
    end

    assign im_addr   = pc;
    assign dbg_state = state;

    // Data memory handshake: dm_req rises on the EXEC->MEM edge and dm_we/dm_addr/dm_wdata stay
    // stable until a one-cycle dm_ack is sampled in MEM; dm_ack in any other state is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            ir       <= '0;
            pc       <= '0;
            z        <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            done     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= im_inst;
                    state <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_LDR, OP_STR: begin
                            dm_req   <= 1'b1;
                            dm_we    <= (op == OP_STR);
                            dm_addr  <= rb_val[AW-1:0];
                            dm_wdata <= ra_val;
                            state    <= MEM;
                        end
                        OP_ADD, OP_SUB, OP_CLR, OP_DEC: begin
                            regs[ra] <= alu_res;
                            z        <= (alu_res == '0);
                            pc       <= pc_inc;
                            state    <= FETCH;
                        end
                        OP_BZ: begin
                            pc    <= z ? pc_br : pc_inc;
                            state <= FETCH;
                        end
                        OP_HLT: begin
                            done  <= 1'b1;
                            state <= HALT;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (dm_ack) begin
                        if (!dm_we) begin
                            regs[ra] <= dm_rdata;
                        end
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        pc     <= pc_inc;
                        state  <= FETCH;
                    end
                end
                HALT: begin
                    done <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef MC_CORE_PERF_EN
    logic retire;

    assign retire = ((state == EXEC) && (op != OP_LDR) && (op != OP_STR))
                  || ((state == MEM) && dm_ack);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if ((state != HALT) && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (retire && (ret_cnt != '1)) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: 8-bit default core with a wait-state data memory and a store
// scoreboard, plus a DW=16/NREG=16 core (performance counters checked when MC_CORE_PERF_EN is set).
module tb_mc_core;

    localparam logic [2:0] LDR = 3'd0;
    localparam logic [2:0] STR = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] CLR = 3'd4;
    localparam logic [2:0] DEC = 3'd5;
    localparam logic [2:0] BZ  = 3'd6;
    localparam logic [2:0] HLT = 3'd7;

    // clock / reset
    logic clk;
    logic reset;
    logic reset_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter core
    logic [7:0]  im_addr;
    logic [8:0]  im_inst;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic        dm_ack;
    logic [7:0]  dm_rdata;
    logic        done;
    logic        z;
    logic [1:0]  dbg_state;
`ifdef MC_CORE_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    logic [8:0]  imem [256];
    logic [7:0]  dmem [256];
    logic        resp_ack;
    logic        man_ack;
    int          wait_n;

    assign im_inst = imem[im_addr];
    assign dm_ack  = resp_ack | man_ack;

    mc_core u_dut (
        .clk      (clk),
        .reset    (reset),
        .im_addr  (im_addr),
        .im_inst  (im_inst),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .done     (done),
        .z        (z),
`ifdef MC_CORE_PERF_EN
        .cyc_cnt  (cyc_cnt),
        .ret_cnt  (ret_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // wide core: DW=16, NREG=16, IW=11
    logic [7:0]  im_addr_w;
    logic [10:0] im_inst_w;
    logic        dm_req_w;
    logic        dm_we_w;
    logic [7:0]  dm_addr_w;
    logic [15:0] dm_wdata_w;
    logic        ack_w;
    logic [15:0] dm_rdata_w;
    logic        done_w;
    logic        z_w;
    logic [1:0]  dbg_state_w;
`ifdef MC_CORE_PERF_EN
    logic [31:0] cyc_cnt_w;
    logic [31:0] ret_cnt_w;
`endif
    logic [10:0] imem_w [256];

    assign im_inst_w  = imem_w[im_addr_w];
    assign dm_rdata_w = 16'h0000;

    mc_core #(.DW(16), .NREG(16), .PCW(8), .AW(8)) u_dut_w (
        .clk      (clk),
        .reset    (reset_w),
        .im_addr  (im_addr_w),
        .im_inst  (im_inst_w),
        .dm_req   (dm_req_w),
        .dm_we    (dm_we_w),
        .dm_addr  (dm_addr_w),
        .dm_wdata (dm_wdata_w),
        .dm_ack   (ack_w),
        .dm_rdata (dm_rdata_w),
        .done     (done_w),
        .z        (z_w),
`ifdef MC_CORE_PERF_EN
        .cyc_cnt  (cyc_cnt_w),
        .ret_cnt  (ret_cnt_w),
`endif
        .dbg_state(dbg_state_w)
    );

    // check bookkeeping and scoreboard ({addr, data} of each expected store)
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // zero-wait responder for the wide core
    initial ack_w = 1'b0;
    always @(negedge clk) ack_w = dm_req_w && !ack_w;

    // wait-state responder for the default core; checks request stability and pops the scoreboard
    int          req_cyc = 0;
    logic [7:0]  first_addr;
    logic [7:0]  first_wdata;
    logic        first_we;
    logic [15:0] exp_item;

    initial begin
        resp_ack = 1'b0;
        dm_rdata = 8'h00;
    end

    always @(negedge clk) begin
        if (dm_req && !resp_ack) begin
            if (req_cyc == 0) begin
                first_addr  = dm_addr;
                first_wdata = dm_wdata;
                first_we    = dm_we;
            end else begin
                check("hold_addr", 32'(dm_addr), 32'(first_addr));
                check("hold_wdata", 32'(dm_wdata), 32'(first_wdata));
                check("hold_we", 32'(dm_we), 32'(first_we));
            end
            if (req_cyc == wait_n) begin
                resp_ack = 1'b1;
                if (dm_we) begin
                    dmem[dm_addr] = dm_wdata;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_store", 32'(exp_q.size()), 1);
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("sb_store", 32'({dm_addr, dm_wdata}), 32'(exp_item));
                    end
                    dm_rdata = 8'h00;
                end else begin
                    dm_rdata = dmem[dm_addr];
                end
                req_cyc = 0;
            end else begin
                resp_ack = 1'b0;
                dm_rdata = 8'h00;
                req_cyc++;
            end
        end else begin
            resp_ack = 1'b0;
            dm_rdata = 8'h00;
            req_cyc  = 0;
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = {HLT, 6'h00};
            dmem[i] = 8'h00;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        check("done_reached", 32'(done), 1);
    endtask

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
        return {op, ra, rb};
    endfunction

    function automatic logic [8:0] bz(input logic [5:0] off);
        return {BZ, off};
    endfunction

    function automatic logic [10:0] ins_w(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb);
        return {op, ra, rb};
    endfunction

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // directed sequence
    initial begin
        reset   = 1'b0;
        reset_w = 1'b0;
        man_ack = 1'b0;
        wait_n  = 0;
        clear_mem();
        for (int i = 0; i < 256; i++) imem_w[i] = {HLT, 8'h00};

        // ALU + zero flag, results observed through zero-wait stores
        imem[0] = ins(CLR, 3'd1, 3'd0);
        imem[1] = ins(STR, 3'd1, 3'd0);
        imem[2] = ins(DEC, 3'd1, 3'd0);
        imem[3] = ins(STR, 3'd1, 3'd0);
        imem[4] = ins(ADD, 3'd1, 3'd1);
        imem[5] = ins(STR, 3'd1, 3'd0);
        imem[6] = ins(SUB, 3'd1, 3'd1);
        imem[7] = ins(STR, 3'd1, 3'd0);
        imem[8] = {HLT, 6'h00};
        exp_q.push_back({8'h00, 8'h00});
        exp_q.push_back({8'h00, 8'hFF});
        exp_q.push_back({8'h00, 8'hFE});
        exp_q.push_back({8'h00, 8'h00});

        step(3);
        check("rst_im_addr", 32'(im_addr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dm_req", 32'(dm_req), 0);
        check("rst_dm_we", 32'(dm_we), 0);
        check("rst_dm_addr", 32'(dm_addr), 0);
        check("rst_dm_wdata", 32'(dm_wdata), 0);
        check("rst_z", 32'(z), 0);
        check("rst_state", 32'(dbg_state), 0);
        reset = 1'b1;

        step(1);
        check("fetch0_state", 32'(dbg_state), 1);
        check("fetch0_addr", 32'(im_addr), 0);
        step(1);
        check("clr_pc", 32'(im_addr), 1);
        check("clr_z", 32'(z), 1);
        step(3);
        check("str0_pc", 32'(im_addr), 2);
        step(2);
        check("dec_pc", 32'(im_addr), 3);
        check("dec_z", 32'(z), 0);
        step(5);
        check("add_pc", 32'(im_addr), 5);
        check("add_z", 32'(z), 0);
        step(5);
        check("sub_pc", 32'(im_addr), 7);
        check("sub_z", 32'(z), 1);
        wait_done(20);
        check("hlt_pc", 32'(im_addr), 8);
        step(5);
        check("hlt_pc_frozen", 32'(im_addr), 8);
        check("hlt_done_held", 32'(done), 1);
        check("hlt_no_req", 32'(dm_req), 0);
        check("hlt_state", 32'(dbg_state), 3);
        check("sb_drain_alu", 32'(exp_q.size()), 0);

        // load/store with three wait states
        reset = 1'b0;
        step(1);
        clear_mem();
        wait_n = 3;
        dmem[8'h00] = 8'h10;
        dmem[8'h10] = 8'h20;
        dmem[8'h20] = 8'h5A;
        imem[0] = ins(CLR, 3'd6, 3'd0);
        imem[1] = ins(LDR, 3'd2, 3'd0);
        imem[2] = ins(LDR, 3'd7, 3'd2);
        imem[3] = ins(LDR, 3'd3, 3'd7);
        imem[4] = ins(STR, 3'd3, 3'd2);
        imem[5] = ins(LDR, 3'd4, 3'd2);
        imem[6] = ins(STR, 3'd4, 3'd0);
        exp_q.push_back({8'h10, 8'h5A});
        exp_q.push_back({8'h00, 8'h5A});
        reset = 1'b1;
        step(2);
        check("ls_clr_z", 32'(z), 1);
        check("ls_pc1", 32'(im_addr), 1);
        step(6);
        check("ls_ldr_6cyc", 32'(im_addr), 2);
        wait_done(80);
        check("ls_z_kept", 32'(z), 1);
        check("ls_mem10", 32'(dmem[8'h10]), 32'h5A);
        check("sb_drain_ls", 32'(exp_q.size()), 0);

        // branches, including PC wrap in both directions
        reset = 1'b0;
        step(1);
        clear_mem();
        wait_n = 0;
        imem[8'h00] = bz(6'h3F);
        imem[8'h01] = ins(CLR, 3'd1, 3'd0);
        imem[8'h02] = bz(6'h3E);
        imem[8'hFF] = bz(6'h31);
        imem[8'hF0] = bz(6'h1F);
        reset = 1'b1;
        step(2);
        check("bz_not_taken", 32'(im_addr), 1);
        step(2);
        check("bz_clr_z", 32'(z), 1);
        step(2);
        check("bz_back", 32'(im_addr), 0);
        step(2);
        check("bz_wrap_down", 32'(im_addr), 32'hFF);
        step(2);
        check("bz_neg15", 32'(im_addr), 32'hF0);
        step(2);
        check("bz_wrap_up", 32'(im_addr), 32'h0F);
        check("bz_z_kept", 32'(z), 1);
        wait_done(10);

        // reset while a load waits in MEM, then stray acks outside MEM
        reset = 1'b0;
        step(1);
        clear_mem();
        wait_n = 10;
        dmem[0] = 8'h33;
        imem[0] = ins(LDR, 3'd5, 3'd0);
        reset = 1'b1;
        step(2);
        check("ab_req", 32'(dm_req), 1);
        check("ab_state_mem", 32'(dbg_state), 2);
        step(1);
        reset = 1'b0;
        step(1);
        check("ab_req_drop", 32'(dm_req), 0);
        check("ab_state_fetch", 32'(dbg_state), 0);
        wait_n = 2;
        imem[0] = ins(STR, 3'd5, 3'd0);
        exp_q.push_back({8'h00, 8'h00});
        man_ack = 1'b1;
        reset   = 1'b1;
        step(1);
        check("late_ack_exec", 32'(dbg_state), 1);
        step(1);
        check("rise_ack_ignored_req", 32'(dm_req), 1);
        check("rise_ack_ignored_state", 32'(dbg_state), 2);
        man_ack = 1'b0;
        step(3);
        check("ab_str_pc", 32'(im_addr), 1);
        check("ab_str_req_low", 32'(dm_req), 0);
        wait_done(10);
        check("ab_mem0", 32'(dmem[0]), 0);
        check("sb_drain_ab", 32'(exp_q.size()), 0);

        // wide core
        imem_w[0] = ins_w(DEC, 4'd15, 4'd0);
        imem_w[1] = ins_w(ADD, 4'd14, 4'd15);
        imem_w[2] = ins_w(SUB, 4'd14, 4'd15);
        imem_w[3] = ins_w(CLR, 4'd13, 4'd0);
        imem_w[4] = ins_w(DEC, 4'd13, 4'd0);
        imem_w[5] = ins_w(STR, 4'd15, 4'd0);
        reset_w = 1'b1;
        step(2);
        check("w_dec_z", 32'(z_w), 0);
        check("w_dec_pc", 32'(im_addr_w), 1);
        step(4);
        check("w_sub_z", 32'(z_w), 1);
        step(2);
        check("w_clr_z", 32'(z_w), 1);
        step(2);
        check("w_dec13_z", 32'(z_w), 0);
        check("w_pc5", 32'(im_addr_w), 5);
`ifdef MC_CORE_PERF_EN
        check("w_ret5", ret_cnt_w, 5);
        check("w_cyc10", cyc_cnt_w, 10);
`endif
        step(2);
        check("w_req", 32'(dm_req_w), 1);
        check("w_we", 32'(dm_we_w), 1);
        check("w_r15_ffff", 32'(dm_wdata_w), 32'hFFFF);
        check("w_addr", 32'(dm_addr_w), 0);
        step(1);
        check("w_req_drop", 32'(dm_req_w), 0);
        check("w_pc6", 32'(im_addr_w), 6);
        step(2);
        check("w_done", 32'(done_w), 1);
        step(3);
        check("w_pc_frozen", 32'(im_addr_w), 6);
`ifdef MC_CORE_PERF_EN
        check("w_ret_final", ret_cnt_w, 7);
        check("w_cyc_final", cyc_cnt_w, 15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
